vga_mode_ctrl: RTL and testbench

//  Owns the timing configuration of the VGA timing core. Holds a 4-entry VESA mode table, drives the

---
 rtl/vga_mode_ctrl.sv | 153 +++++++++++++++
 tb/tb_vga_mode_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_mode_ctrl.sv
// VGA mode controller: holds the VESA timing table, drives the timing core's configuration
// and reset, and sequences mode switches at end of frame.
module vga_mode_ctrl #(
    parameter int DEFAULT_MODE    = 0,
    parameter int RST_HOLD_CYCLES = 16,
    parameter bit WAIT_FRAME_END  = 1'b1,
    parameter int EOF_TIMEOUT     = 2**24
) (
    input  logic        pxl_clk,
    input  logic        pxl_rst,
    input  logic        mode_req_valid,
    input  logic [2:0]  mode_req_sel,
    output logic        mode_req_ready,
    output logic        mode_req_err,
    output logic        mode_done,
    output logic        mode_locked,
    output logic [1:0]  cur_mode,
    input  logic        vert_active,
    output logic        core_rst,
    output logic [31:0] horz_res,
    output logic [31:0] horz_front,
    output logic [31:0] horz_back,
    output logic [31:0] horz_sync_len,
    output logic [31:0] vert_res,
    output logic [31:0] vert_front,
    output logic [31:0] vert_back,
    output logic [31:0] vert_sync_len,
    output logic        hsync_pol,
    output logic        vsync_pol
);

    // state    | meaning
    // HOLD     | core held in reset while the loaded timing settles
    // RUN      | core running a stable mode, requests accepted
    // WAIT_EOF | new mode latched, core still running, waiting for frame end or timeout
    // SWITCH   | load new timing and put the core back into reset
    typedef enum logic [1:0] {HOLD, RUN, WAIT_EOF, SWITCH} state_t;

    typedef struct packed {
        logic [31:0] h_res;
        logic [31:0] h_fp;
        logic [31:0] h_bp;
        logic [31:0] h_sync;
        logic [31:0] v_res;
        logic [31:0] v_fp;
        logic [31:0] v_bp;
        logic [31:0] v_sync;
        logic        h_pol;
        logic        v_pol;
    } timing_t;

    localparam int HW = $clog2(RST_HOLD_CYCLES);
    localparam int TW = (EOF_TIMEOUT > 1) ? $clog2(EOF_TIMEOUT) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(RST_HOLD_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(EOF_TIMEOUT - 1);
    localparam logic [1:0]    DEF_MODE  = 2'(DEFAULT_MODE);

    function automatic timing_t mode_entry(input logic [1:0] m);
        timing_t t;
        case (m)
            2'd0:    t = '{32'd640,  32'd16, 32'd48,  32'd96,  32'd480,  32'd10, 32'd33, 32'd2, 1'b0, 1'b0};
            2'd1:    t = '{32'd800,  32'd40, 32'd88,  32'd128, 32'd600,  32'd1,  32'd23, 32'd4, 1'b1, 1'b1};
            2'd2:    t = '{32'd1024, 32'd24, 32'd160, 32'd136, 32'd768,  32'd3,  32'd29, 32'd6, 1'b0, 1'b0};
            default: t = '{32'd1280, 32'd48, 32'd248, 32'd112, 32'd1024, 32'd1,  32'd38, 32'd3, 1'b1, 1'b1};
        endcase
        return t;
    endfunction

    state_t          state;
    timing_t         cfg;
    logic [HW-1:0]   hold_cnt;
    logic [TW-1:0]   to_cnt;
    logic [1:0]      pend_mode;
    logic            vert_active_q;

    assign horz_res      = cfg.h_res;
    assign horz_front    = cfg.h_fp;
    assign horz_back     = cfg.h_bp;
    assign horz_sync_len = cfg.h_sync;
    assign vert_res      = cfg.v_res;
    assign vert_front    = cfg.v_fp;
    assign vert_back     = cfg.v_bp;
    assign vert_sync_len = cfg.v_sync;
    assign hsync_pol     = cfg.h_pol;
    assign vsync_pol     = cfg.v_pol;

    always_ff @(posedge pxl_clk or posedge pxl_rst) begin
        if (pxl_rst) begin
            state          <= HOLD;
            cfg            <= mode_entry(DEF_MODE);
            cur_mode       <= DEF_MODE;
            pend_mode      <= DEF_MODE;
            hold_cnt       <= '0;
            to_cnt         <= '0;
            vert_active_q  <= 1'b0;
            core_rst       <= 1'b1;
            mode_req_ready <= 1'b0;
            mode_locked    <= 1'b0;
            mode_req_err   <= 1'b0;
            mode_done      <= 1'b0;
        end else begin
            mode_req_err <= 1'b0;
            mode_done    <= 1'b0;
            case (state)
                HOLD: begin
                    vert_active_q <= 1'b0;
                    if (hold_cnt == HOLD_LAST) begin
                        state          <= RUN;
                        core_rst       <= 1'b0;
                        mode_done      <= 1'b1;
                        mode_locked    <= 1'b1;
                        mode_req_ready <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                RUN: begin
                    vert_active_q <= vert_active;
                    if (mode_req_valid && mode_req_ready) begin
                        if (mode_req_sel[2]) begin
                            mode_req_err <= 1'b1;
                        end else if (mode_req_sel[1:0] != cur_mode) begin
                            pend_mode      <= mode_req_sel[1:0];
                            mode_req_ready <= 1'b0;
                            to_cnt         <= '0;
                            state          <= WAIT_FRAME_END ? WAIT_EOF : SWITCH;
                        end
                    end
                end
                WAIT_EOF: begin
                    vert_active_q <= vert_active;
                    // a frame that never ends must not block the switch forever
                    if ((vert_active_q && !vert_active) || to_cnt == TO_LAST) begin
                        state <= SWITCH;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                SWITCH: begin
                    cfg           <= mode_entry(pend_mode);
                    cur_mode      <= pend_mode;
                    core_rst      <= 1'b1;
                    mode_locked   <= 1'b0;
                    hold_cnt      <= '0;
                    vert_active_q <= 1'b0;
                    state         <= HOLD;
                end
                default: state <= HOLD;
            endcase
        end
    end

endmodule

// File: tb/tb_vga_mode_ctrl.sv
// Bench for vga_mode_ctrl: three instances (immediate switch, frame-end switch, short timeout)
// with a transaction scoreboard fed by the stimulus and drained by a negedge monitor.
module tb_vga_mode_ctrl;

    localparam int HOLD_CYC = 16;
    localparam int TO_CYC   = 64;
    localparam int ND       = 3;

    typedef struct {
        int     dut;
        bit     is_err;
        int     mode;
        longint acc;
    } ev_t;

    int t_h_res [4] = '{640, 800, 1024, 1280};
    int t_h_fp  [4] = '{16, 40, 24, 48};
    int t_h_bp  [4] = '{48, 88, 160, 248};
    int t_h_sy  [4] = '{96, 128, 136, 112};
    int t_v_res [4] = '{480, 600, 768, 1024};
    int t_v_fp  [4] = '{10, 1, 3, 1};
    int t_v_bp  [4] = '{33, 23, 29, 38};
    int t_v_sy  [4] = '{2, 4, 6, 3};
    int t_pol   [4] = '{0, 1, 0, 1};

    logic        pxl_clk = 1'b0;
    logic        pxl_rst   [ND];
    logic        req_valid [ND];
    logic [2:0]  req_sel   [ND];
    logic        req_ready [ND];
    logic        req_err   [ND];
    logic        done      [ND];
    logic        locked    [ND];
    logic [1:0]  cur_mode  [ND];
    logic        vact      [ND];
    logic        core_rst  [ND];
    logic [31:0] h_res [ND], h_fp [ND], h_bp [ND], h_sy [ND];
    logic [31:0] v_res [ND], v_fp [ND], v_bp [ND], v_sy [ND];
    logic        hpol [ND], vpol [ND];

    always #5 pxl_clk = ~pxl_clk;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        vga_mode_ctrl #(
            .DEFAULT_MODE    (0),
            .RST_HOLD_CYCLES (HOLD_CYC),
            .WAIT_FRAME_END  (g != 0),
            .EOF_TIMEOUT     (g == 2 ? TO_CYC : 2**24)
        ) dut (
            .pxl_clk        (pxl_clk),
            .pxl_rst        (pxl_rst[g]),
            .mode_req_valid (req_valid[g]),
            .mode_req_sel   (req_sel[g]),
            .mode_req_ready (req_ready[g]),
            .mode_req_err   (req_err[g]),
            .mode_done      (done[g]),
            .mode_locked    (locked[g]),
            .cur_mode       (cur_mode[g]),
            .vert_active    (vact[g]),
            .core_rst       (core_rst[g]),
            .horz_res       (h_res[g]),
            .horz_front     (h_fp[g]),
            .horz_back      (h_bp[g]),
            .horz_sync_len  (h_sy[g]),
            .vert_res       (v_res[g]),
            .vert_front     (v_fp[g]),
            .vert_back      (v_bp[g]),
            .vert_sync_len  (v_sy[g]),
            .hsync_pol      (hpol[g]),
            .vsync_pol      (vpol[g])
        );
    end

    int     n_chk = 0;
    int     n_fail = 0;
    longint cyc = 0;
    ev_t    exp_q [$];
    int     model_mode [ND];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_mode(input int d, input int m);
        check("done_cur_mode", cur_mode[d], m);
        check("done_horz_res", h_res[d], t_h_res[m]);
        check("done_horz_front", h_fp[d], t_h_fp[m]);
        check("done_horz_back", h_bp[d], t_h_bp[m]);
        check("done_horz_sync", h_sy[d], t_h_sy[m]);
        check("done_vert_res", v_res[d], t_v_res[m]);
        check("done_vert_front", v_fp[d], t_v_fp[m]);
        check("done_vert_back", v_bp[d], t_v_bp[m]);
        check("done_vert_sync", v_sy[d], t_v_sy[m]);
        check("done_hsync_pol", hpol[d], t_pol[m]);
        check("done_vsync_pol", vpol[d], t_pol[m]);
    endtask

    task automatic expect_ev(input int d, input bit is_err, input int mode, input longint acc);
        ev_t e;
        e.dut    = d;
        e.is_err = is_err;
        e.mode   = mode;
        e.acc    = acc;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge pxl_clk);
        #1;
    endtask

    // Waits for ready, presents one request and records what the spec says must follow.
    task automatic issue(input int d, input int sel);
        int n = 0;
        while (!req_ready[d] && n < 5000) begin
            step();
            n++;
        end
        check("issue_ready_wait", req_ready[d], 1);
        if (!req_ready[d]) return;
        req_valid[d] = 1'b1;
        req_sel[d]   = 3'(sel);
        if (sel >= 4) begin
            expect_ev(d, 1'b1, 0, -1);
        end else if (sel != model_mode[d]) begin
            expect_ev(d, 1'b0, sel, (d == 0) ? cyc + 1 : -1);
            model_mode[d] = sel;
        end
        step();
        req_valid[d] = 1'b0;
        req_sel[d]   = 3'($urandom_range(0, 7));
    endtask

    // Runs until the scoreboard drains, poking ignored requests and toggling vert_active.
    task automatic wait_idle(input int d, input int budget);
        int n = 0;
        while (n < budget) begin
            req_valid[d] = 1'b0;
            if (exp_q.size() == 0 && req_ready[d]) break;
            if (!req_ready[d] && $urandom_range(0, 3) == 0) begin
                req_valid[d] = 1'b1;
                req_sel[d]   = 3'($urandom_range(0, 7));
            end
            if ($urandom_range(0, 7) == 0) vact[d] = ~vact[d];
            step();
            n++;
        end
        req_valid[d] = 1'b0;
        check("wait_idle_budget", (exp_q.size() == 0 && req_ready[d]), 1);
    endtask

    int          run_len   [ND];
    logic [257:0] prev_t   [ND];
    logic        prev_core [ND];

    always @(negedge pxl_clk) begin
        ev_t ev;
        logic [257:0] cur_t;
        cyc++;
        for (int d = 0; d < ND; d++) begin
            cur_t = {h_res[d], h_fp[d], h_bp[d], h_sy[d], v_res[d], v_fp[d], v_bp[d], v_sy[d],
                     hpol[d], vpol[d]};
            if (!pxl_rst[d]) begin
                if (cur_t !== prev_t[d])
                    check("timing_change_on_hold_entry", {prev_core[d], core_rst[d]}, 2'b01);
                if (core_rst[d]) check("ready_low_in_hold", req_ready[d], 0);
                if (req_err[d] || done[d]) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_event", {req_err[d], done[d]}, 0);
                    end else begin
                        ev = exp_q.pop_front();
                        check("event_dut", d, ev.dut);
                        check("event_err", req_err[d], ev.is_err);
                        check("event_done", done[d], !ev.is_err);
                        if (done[d] && !ev.is_err) begin
                            check_mode(d, ev.mode);
                            check("core_rst_hold_len", run_len[d], HOLD_CYC);
                            check("done_core_rst_low", core_rst[d], 0);
                            check("done_ready", req_ready[d], 1);
                            check("done_locked", locked[d], 1);
                            if (ev.acc >= 0) check("done_latency", cyc - ev.acc, 2 + HOLD_CYC);
                        end
                    end
                end
                run_len[d] = core_rst[d] ? run_len[d] + 1 : 0;
            end else begin
                run_len[d] = 0;
            end
            prev_t[d]    = cur_t;
            prev_core[d] = core_rst[d];
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, %0d checks %0d failures", n_chk, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        int hi;
        for (int d = 0; d < ND; d++) begin
            pxl_rst[d]    = 1'b1;
            req_valid[d]  = 1'b0;
            req_sel[d]    = 3'd0;
            vact[d]       = 1'b0;
            model_mode[d] = 0;
            run_len[d]    = 0;
        end
        repeat (3) step();

        // reset state
        for (int d = 0; d < ND; d++) begin
            check("rst_core_rst", core_rst[d], 1);
            check("rst_ready", req_ready[d], 0);
            check("rst_locked", locked[d], 0);
            check("rst_done", done[d], 0);
            check("rst_err", req_err[d], 0);
            check("rst_cur_mode", cur_mode[d], 0);
            check("rst_horz_res", h_res[d], 640);
            check("rst_vert_sync", v_sy[d], 2);
            check("rst_hsync_pol", hpol[d], 0);
            expect_ev(d, 1'b0, 0, -1);
        end
        for (int d = 0; d < ND; d++) pxl_rst[d] = 1'b0;
        wait_idle(0, 100);

        // immediate switch to mode 2
        issue(0, 2);
        check("sw2_timing_before", h_res[0], 640);
        step();
        check("sw2_horz_res", h_res[0], 1024);
        check("sw2_core_rst", core_rst[0], 1);
        check("sw2_vert_back", v_bp[0], 29);
        check("sw2_hsync_pol", hpol[0], 0);
        wait_idle(0, 100);

        // invalid index, then same-mode no-op
        issue(0, 5);
        check("err_pulse", req_err[0], 1);
        check("err_cur_mode", cur_mode[0], 2);
        check("err_core_rst", core_rst[0], 0);
        step();
        check("err_one_cycle", req_err[0], 0);
        issue(0, 2);
        hi = 0;
        repeat (24) begin
            if (core_rst[0] || !req_ready[0]) hi++;
            step();
        end
        check("noop_no_switch", hi, 0);
        check("noop_cur_mode", cur_mode[0], 2);

        repeat (30) begin
            issue(0, $urandom_range(0, 7));
            wait_idle(0, 200);
        end

        // reset during the hold of a 0->3 switch
        if (model_mode[0] != 0) begin
            issue(0, 0);
            wait_idle(0, 200);
        end
        issue(0, 3);
        repeat (6) step();
        check("abort_hold_core_rst", core_rst[0], 1);
        check("abort_hold_new_timing", h_res[0], 1280);
        pxl_rst[0] = 1'b1;
        #1;
        check("abort_core_rst", core_rst[0], 1);
        check("abort_horz_res", h_res[0], 640);
        check("abort_vert_res", v_res[0], 480);
        check("abort_cur_mode", cur_mode[0], 0);
        check("abort_vsync_pol", vpol[0], 0);
        check("abort_ready", req_ready[0], 0);
        exp_q.delete();
        model_mode[0] = 0;
        expect_ev(0, 1'b0, 0, -1);
        repeat (3) step();
        pxl_rst[0] = 1'b0;
        wait_idle(0, 100);

        // frame-end deferred switch to mode 1
        vact[1] = 1'b1;
        step();
        issue(1, 1);
        bad = 0;
        repeat (100) begin
            if (h_res[1] != 640 || core_rst[1] || req_ready[1] || !locked[1]) bad++;
            req_valid[1] = ($urandom_range(0, 1) == 1);
            req_sel[1]   = 3'($urandom_range(0, 7));
            step();
        end
        req_valid[1] = 1'b0;
        check("eof_no_change_before", bad, 0);
        vact[1] = 1'b0;
        step();
        check("eof_timing_at_e1", h_res[1], 640);
        step();
        check("eof_horz_res", h_res[1], 800);
        check("eof_vert_res", v_res[1], 600);
        check("eof_horz_sync", h_sy[1], 128);
        check("eof_hsync_pol", hpol[1], 1);
        check("eof_vsync_pol", vpol[1], 1);
        check("eof_core_rst", core_rst[1], 1);
        wait_idle(1, 100);

        // forced switch after timeout with vert_active stuck low
        issue(2, 3);
        repeat (64) step();
        check("timeout_not_early_res", h_res[2], 640);
        check("timeout_not_early_rst", core_rst[2], 0);
        step();
        check("timeout_horz_res", h_res[2], 1280);
        check("timeout_core_rst", core_rst[2], 1);
        check("timeout_cur_mode", cur_mode[2], 3);
        wait_idle(2, 100);

        repeat (10) begin
            issue(1, $urandom_range(0, 4));
            wait_idle(1, 3000);
        end

        repeat (4) step();
        check("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
